// File: rtl/fma_sched.sv
// Issue scheduler for an external FP8 x FP8 + FP16 MAC pipeline with NTAG accumulators.
// Optional perf counters are enabled by defining FMA_SCHED_PERF_EN.
module fma_sched #(
    parameter int PIPE_LAT = 4,
    parameter int NTAG     = 4,
    localparam int TW      = $clog2(NTAG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_a,
    input  logic [7:0]    in_b,
    input  logic          in_afmt,
    input  logic          in_bfmt,
    input  logic [TW-1:0] in_tag,
    input  logic          in_first,
    input  logic          in_last,
    output logic [7:0]    pipe_a,
    output logic [7:0]    pipe_b,
    output logic          pipe_afmt,
    output logic          pipe_bfmt,
    output logic [15:0]   pipe_c,
    output logic          pipe_save,
    input  logic [15:0]   pipe_s,
    input  logic          pipe_saveout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [TW-1:0] out_tag,
    output logic [15:0]   out_sum,
`ifdef FMA_SCHED_PERF_EN
    output logic [15:0]   perf_issued,
    output logic [15:0]   perf_stall,
`endif
    output logic          err
);

    localparam int LW = $clog2(PIPE_LAT + 2);
    localparam int GW = $clog2(PIPE_LAT + 1);
    localparam logic [GW-1:0] GUARD_MAX = GW'(PIPE_LAT);

    typedef struct packed {
        logic          vld;
        logic [TW-1:0] tag;
        logic          last;
    } sr_t;

    sr_t              sr_q [PIPE_LAT+1];
    logic [NTAG-1:0]  busy_q, busy_d, clr_mask, set_mask;
    logic [15:0]      acc_q [NTAG];
    logic [TW+15:0]   fifo_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       cnt_q, cnt_d;
    logic [GW-1:0]    guard_q;
    logic             err_q;
    logic             pipe_save_q, pipe_afmt_q, pipe_bfmt_q;
    logic [7:0]       pipe_a_q, pipe_b_q;
    logic [15:0]      pipe_c_q, c_sel;
    logic [LW-1:0]    lif;
    logic [LW:0]      pend;
    logic             room, accept, push, pop;
    sr_t              ret;

    // Both handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready may depend combinationally on the offered tag/last.
    assign ret = sr_q[PIPE_LAT];

    always_comb begin
        lif = '0;
        for (int i = 0; i <= PIPE_LAT; i++) begin
            lif = lif + LW'(sr_q[i].vld & sr_q[i].last);
        end
        pend = {1'b0, lif} + (LW+1)'(cnt_q);
        room = (pend < (LW+1)'(2));
    end

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (ret.vld) clr_mask[ret.tag] = 1'b1;
        if (accept) set_mask[in_tag] = 1'b1;
        busy_d = (busy_q & ~clr_mask) | set_mask;
    end

    // A tag retiring this cycle is already free, so it can be reissued back-to-back.
    assign in_ready = rst_n && !(busy_q[in_tag] && !clr_mask[in_tag]) && (!in_last || room);
    assign accept   = in_valid && in_ready;

    // The retiring result bypasses acc when the same tag is reissued in that cycle.
    always_comb begin
        c_sel = acc_q[in_tag];
        if (in_first) c_sel = 16'h0000;
        else if (ret.vld && ret.tag == in_tag) c_sel = pipe_s;
    end

    assign push      = ret.vld && ret.last;
    assign out_valid = (cnt_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign {out_tag, out_sum} = fifo_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) cnt_d = cnt_q + 2'd1;
        else if (pop && !push) cnt_d = cnt_q - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= PIPE_LAT; i++) sr_q[i] <= '0;
            for (int i = 0; i < NTAG; i++) acc_q[i] <= '0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            busy_q      <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= '0;
            guard_q     <= '0;
            err_q       <= 1'b0;
            pipe_save_q <= 1'b0;
            pipe_a_q    <= '0;
            pipe_b_q    <= '0;
            pipe_afmt_q <= 1'b0;
            pipe_bfmt_q <= 1'b0;
            pipe_c_q    <= '0;
        end else begin
            sr_q[0] <= '{vld: accept, tag: in_tag, last: in_last};
            for (int i = 1; i <= PIPE_LAT; i++) sr_q[i] <= sr_q[i-1];
            busy_q <= busy_d;
            if (ret.vld) acc_q[ret.tag] <= pipe_s;
            if (push) begin
                fifo_q[wr_ptr_q] <= {ret.tag, pipe_s};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_d;
            // Results of operations issued before reset may still emerge; ignore them.
            if (guard_q != GUARD_MAX) guard_q <= guard_q + 1'b1;
            else if (pipe_saveout != ret.vld) err_q <= 1'b1;
            pipe_save_q <= accept;
            pipe_a_q    <= accept ? in_a : 8'h00;
            pipe_b_q    <= accept ? in_b : 8'h00;
            pipe_afmt_q <= accept && in_afmt;
            pipe_bfmt_q <= accept && in_bfmt;
            pipe_c_q    <= accept ? c_sel : 16'h0000;
        end
    end

    assign pipe_save = pipe_save_q;
    assign pipe_a    = pipe_a_q;
    assign pipe_b    = pipe_b_q;
    assign pipe_afmt = pipe_afmt_q;
    assign pipe_bfmt = pipe_bfmt_q;
    assign pipe_c    = pipe_c_q;
    assign err       = err_q;

`ifdef FMA_SCHED_PERF_EN
    logic [15:0] issued_q, stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            if (accept && issued_q != 16'hFFFF) issued_q <= issued_q + 16'd1;
            if (in_valid && !in_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
        end
    end

    assign perf_issued = issued_q;
    assign perf_stall  = stall_q;
`endif

endmodule

// File: tb/tb_fma_sched.sv
// Bench for fma_sched: a real-arithmetic MAC pipeline stand-in plus a per-tag running-sum
// reference model with an expected-output queue.
module tb_fma_sched;
    localparam int PIPE_LAT = 4;
    localparam int NTAG     = 4;
    localparam int TW       = 2;
    localparam int W        = TW + 16;

    logic          clk, rst_n;
    logic          in_valid, in_ready, in_afmt, in_bfmt, in_first, in_last;
    logic [7:0]    in_a, in_b, pipe_a, pipe_b;
    logic [TW-1:0] in_tag, out_tag;
    logic          pipe_afmt, pipe_bfmt, pipe_save, pipe_saveout;
    logic [15:0]   pipe_c, pipe_s, out_sum;
    logic          out_valid, out_ready, err;
`ifdef FMA_SCHED_PERF_EN
    logic [15:0]   perf_issued, perf_stall;
`endif

    fma_sched #(.PIPE_LAT(PIPE_LAT), .NTAG(NTAG)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_afmt(in_afmt), .in_bfmt(in_bfmt), .in_tag(in_tag),
        .in_first(in_first), .in_last(in_last),
        .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_afmt(pipe_afmt), .pipe_bfmt(pipe_bfmt),
        .pipe_c(pipe_c), .pipe_save(pipe_save), .pipe_s(pipe_s), .pipe_saveout(pipe_saveout),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_sum(out_sum),
`ifdef FMA_SCHED_PERF_EN
        .perf_issued(perf_issued), .perf_stall(perf_stall),
`endif
        .err(err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // arithmetic helpers (exact for the small operand set used here)
    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) repeat (e) r = r * 2.0;
        else repeat (-e) r = r / 2.0;
        return r;
    endfunction

    function automatic real fp8_val(input logic [7:0] x, input logic e4m3);
        int e, m;
        real v;
        if (e4m3) begin
            e = int'(x[6:3]); m = int'(x[2:0]);
            v = (e == 0) ? (m / 8.0) * pow2(-6) : (1.0 + m / 8.0) * pow2(e - 7);
        end else begin
            e = int'(x[6:2]); m = int'(x[1:0]);
            v = (e == 0) ? (m / 4.0) * pow2(-14) : (1.0 + m / 4.0) * pow2(e - 15);
        end
        return x[7] ? -v : v;
    endfunction

    function automatic real fp16_val(input logic [15:0] x);
        int e, m;
        real v;
        e = int'(x[14:10]); m = int'(x[9:0]);
        v = (e == 0) ? (m / 1024.0) * pow2(-14) : (1.0 + m / 1024.0) * pow2(e - 15);
        return x[15] ? -v : v;
    endfunction

    function automatic logic [15:0] to_fp16(input real v);
        real a;
        int e, m;
        logic s;
        if (v == 0.0) return 16'h0000;
        s = (v < 0.0);
        a = s ? -v : v;
        e = 15;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        m = int'((a - 1.0) * 1024.0);
        return {s, e[4:0], m[9:0]};
    endfunction

    // MAC pipeline stand-in: fixed PIPE_LAT latency, not affected by rst_n
    logic [PIPE_LAT-1:0] emu_v = '0;
    logic [15:0]         emu_s [PIPE_LAT];
    logic                force_so;

    always @(posedge clk) begin
        emu_v    <= {emu_v[PIPE_LAT-2:0], pipe_save};
        emu_s[0] <= to_fp16(fp8_val(pipe_a, pipe_afmt) * fp8_val(pipe_b, pipe_bfmt) + fp16_val(pipe_c));
        for (int i = 1; i < PIPE_LAT; i++) emu_s[i] <= emu_s[i-1];
    end
    assign pipe_saveout = emu_v[PIPE_LAT-1] | force_so;
    assign pipe_s       = emu_s[PIPE_LAT-1];

    // reference model and scoreboard
    real            sum_m [NTAG];
    int             last_acc [NTAG];
    int             last_t[$];
    int             fifo_m, cyc, total, bad, run, max_run;
    logic [W-1:0]   exp_q[$];
    logic           exp_save, exp_err, accepted;
    logic [17:0]    exp_pab;
    logic [15:0]    exp_pc;
    logic           s_in_ready, s_out_valid, s_pipe_save, s_err;
    logic [15:0]    s_out_sum, s_pipe_c;
    logic [TW-1:0]  s_out_tag;
    logic [7:0]     tab4 [5];
    logic [7:0]     tab5 [5];

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NTAG; i++) begin sum_m[i] = 0.0; last_acc[i] = -100; end
        last_t.delete();
        exp_q.delete();
        fifo_m = 0; cyc = 0;
        exp_save = 1'b0; exp_pab = '0; exp_pc = '0; exp_err = 1'b0;
    endtask

    // One clock: check outputs mid-cycle, advance the model over the coming edge.
    task automatic tick();
        logic exp_ready, do_pop;
        int   inflight, npush;
        real  prod;
        @(negedge clk);
        inflight = 0;
        npush    = 0;
        foreach (last_t[i]) begin
            if (last_t[i] + 1 + PIPE_LAT >= cyc) inflight++;
            if (last_t[i] + 1 + PIPE_LAT == cyc) npush++;
        end
        exp_ready = (cyc - last_acc[in_tag] >= PIPE_LAT + 1) && (!in_last || fifo_m + inflight < 2);
        check("in_ready", in_ready, exp_ready);
        check("pipe_save", pipe_save, exp_save);
        check("pipe_ab", {pipe_a, pipe_b, pipe_afmt, pipe_bfmt}, exp_pab);
        check("pipe_c", pipe_c, exp_pc);
        check("err", err, exp_err);
        check("out_valid", out_valid, fifo_m > 0);
        if (fifo_m > 0 && exp_q.size() > 0) check("out_word", {out_tag, out_sum}, exp_q[0]);
        s_in_ready = in_ready; s_out_valid = out_valid; s_out_sum = out_sum;
        s_out_tag = out_tag; s_pipe_save = pipe_save; s_pipe_c = pipe_c; s_err = err;
        run = pipe_save ? run + 1 : 0;
        if (run > max_run) max_run = run;

        accepted = in_valid && exp_ready;
        exp_save = accepted;
        exp_pab  = accepted ? {in_a, in_b, in_afmt, in_bfmt} : '0;
        exp_pc   = (accepted && !in_first) ? to_fp16(sum_m[in_tag]) : 16'h0000;
        do_pop   = (fifo_m > 0) && out_ready;
        fifo_m   = fifo_m + npush - (do_pop ? 1 : 0);
        if (do_pop) void'(exp_q.pop_front());
        while (last_t.size() > 0 && last_t[0] + 1 + PIPE_LAT <= cyc) void'(last_t.pop_front());
        if (accepted) begin
            prod = fp8_val(in_a, in_afmt) * fp8_val(in_b, in_bfmt);
            sum_m[in_tag] = in_first ? prod : sum_m[in_tag] + prod;
            last_acc[in_tag] = cyc;
            if (in_last) begin
                last_t.push_back(cyc);
                exp_q.push_back({in_tag, to_fp16(sum_m[in_tag])});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int ncyc);
        in_valid = 1'b0; in_tag = '0; in_last = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_pipe_save", pipe_save, 1'b0);
        check("rst_pipe_c", pipe_c, 16'h0000);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_err", err, 1'b0);
        repeat (ncyc) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic set_term(input int tag, input logic [7:0] a, input logic [7:0] b,
                            input logic af, input logic bf, input logic first, input logic last);
        in_valid = 1'b1; in_tag = tag[TW-1:0]; in_a = a; in_b = b;
        in_afmt = af; in_bfmt = bf; in_first = first; in_last = last;
    endtask

    task automatic wait_accept(output int stalls);
        stalls   = 0;
        accepted = 1'b0;
        for (int k = 0; k < 30 && !accepted; k++) begin
            tick();
            if (!accepted) stalls++;
        end
        check("accept_bound", accepted, 1'b1);
        in_valid = 1'b0;
    endtask

    initial begin
        int st, acc_edge, ps_cyc, ov_cyc, n_out, idx;
        logic [15:0] pc_seen, sum_seen;
        logic [TW-1:0] tag_seen;
        total = 0; bad = 0; run = 0; max_run = 0;
        tab4[0] = 8'h38; tab4[1] = 8'h40; tab4[2] = 8'h30; tab4[3] = 8'h3C; tab4[4] = 8'hB8;
        tab5[0] = 8'h3C; tab5[1] = 8'h40; tab5[2] = 8'h38; tab5[3] = 8'h3E; tab5[4] = 8'hBC;
        in_a = '0; in_b = '0; in_afmt = 1'b0; in_bfmt = 1'b0; in_first = 1'b0;
        force_so = 1'b0; out_ready = 1'b1;
        model_clear();
        do_reset(3);
        repeat (6) tick();

        // single term 1.0*1.0, first and last
        set_term(0, 8'h38, 8'h38, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_accept(st);
        acc_edge = cyc - 1; ps_cyc = -1; ov_cyc = -1;
        pc_seen = 16'hFFFF; sum_seen = 16'hFFFF; tag_seen = '1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (s_pipe_save && ps_cyc < 0) begin ps_cyc = cyc - 1 - acc_edge; pc_seen = s_pipe_c; end
            if (s_out_valid && ov_cyc < 0) begin
                ov_cyc = cyc - 1 - acc_edge; sum_seen = s_out_sum; tag_seen = s_out_tag;
            end
        end
        check("t1_save_cycle", ps_cyc, 1);
        check("t1_pipe_c", pc_seen, 16'h0000);
        check("t1_out_cycle", ov_cyc, 6);
        check("t1_out_sum", sum_seen, 16'h3C00);
        check("t1_out_tag", tag_seen, 0);

        // three chained terms on tag 0
        set_term(0, 8'h38, 8'h38, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_accept(st);
        set_term(0, 8'h38, 8'h38, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_accept(st);
        check("t2_gap_b", st, 4);
        set_term(0, 8'h38, 8'h38, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_accept(st);
        check("t2_gap_c", st, 4);
        sum_seen = 16'hFFFF;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (s_out_valid) sum_seen = s_out_sum;
        end
        check("t2_sum", sum_seen, 16'h4200);

        // four tags back-to-back
        max_run = 0;
        for (int t = 0; t < 4; t++) begin
            set_term(t, 8'h40, 8'h30, 1'b1, 1'b1, 1'b1, 1'b0);
            wait_accept(st);
            check("t3_no_stall", st, 0);
        end
        repeat (8) tick();
        check("t3_save_run", max_run, 4);

        // output FIFO full under backpressure
        out_ready = 1'b0;
        set_term(0, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_accept(st);
        set_term(1, 8'h3E, 8'h40, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_accept(st);
        repeat (6) tick();
        check("t4_full_valid", s_out_valid, 1'b1);
        set_term(2, 8'h38, 8'h38, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t4_refuse_last", s_in_ready, 1'b0);
        end
        in_last = 1'b0;
        wait_accept(st);
        check("t4_non_last_ok", st, 0);
        out_ready = 1'b1;
        repeat (8) tick();
        check("t4_drained", s_out_valid, 1'b0);

        // spurious pipe_saveout
        repeat (2) tick();
        force_so = 1'b1;
        tick();
        force_so = 1'b0;
        exp_err = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_err_sticky", s_err, 1'b1);
        end
        do_reset(2);
        tick();
        check("t5_err_cleared", s_err, 1'b0);

        // reset with an operation in flight
        repeat (6) tick();
        set_term(3, 8'h38, 8'h40, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_accept(st);
        tick();
        do_reset(2);
        set_term(3, 8'h38, 8'h38, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_accept(st);
        check("t6_accept_after_rst", st, 0);
        n_out = 0; sum_seen = 16'hFFFF;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (s_out_valid) begin n_out++; sum_seen = s_out_sum; end
        end
        check("t6_outputs", n_out, 1);
        check("t6_sum", sum_seen, 16'h3C00);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_tag   = TW'($urandom_range(0, NTAG - 1));
            in_first = ($urandom_range(0, 2) == 0);
            in_last  = ($urandom_range(0, 2) == 0);
            in_afmt  = $urandom_range(0, 1) != 0;
            in_bfmt  = $urandom_range(0, 1) != 0;
            idx      = $urandom_range(0, 4);
            in_a     = in_afmt ? tab4[idx] : tab5[idx];
            idx      = $urandom_range(0, 4);
            in_b     = in_bfmt ? tab4[idx] : tab5[idx];
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) tick();
        check("rand_drained", s_out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
